// File: rtl/ecg_sample_writer_if.sv
// Sample stream (valid/ready) and Avalon-MM write-master signals for ecg_sample_writer.
interface ecg_sample_writer_if;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        sample_ready;
  logic [14:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;

  // The writer: consumes the sample stream, drives the Avalon write port.
  modport master (
    input  sample_valid,
    input  sample_data,
    input  avm_waitrequest,
    output sample_ready,
    output avm_address,
    output avm_write,
    output avm_writedata,
    output avm_byteenable
  );

  // The environment: sample source plus the RAM-side slave.
  modport slave (
    output sample_valid,
    output sample_data,
    output avm_waitrequest,
    input  sample_ready,
    input  avm_address,
    input  avm_write,
    input  avm_writedata,
    input  avm_byteenable
  );
endinterface

// File: rtl/ecg_sample_writer.sv
// Packs 16-bit ECG samples two per 32-bit word and writes them into a circular buffer
// in the sample RAM via Avalon-MM, flagging half-buffer and full-buffer boundaries.
module ecg_sample_writer #(
  parameter int unsigned BASE_WORD   = 0,
  parameter int unsigned DEPTH_WORDS = 20480
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                flush,
  ecg_sample_writer_if.master bus,
  output logic [14:0]         wr_ptr,
  output logic [15:0]         wrap_count,
  output logic                half_pulse,
  output logic                full_pulse,
  output logic                busy
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StHalf  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;

  localparam logic [14:0] BaseAddr = 15'(BASE_WORD);
  localparam logic [14:0] LastOff  = 15'(DEPTH_WORDS - 1);
  localparam logic [14:0] HalfOff  = 15'(DEPTH_WORDS / 2 - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  be_q, be_d;
  logic [14:0] wr_ptr_q, wr_ptr_d;
  logic [15:0] wrap_q, wrap_d;
  logic        half_q, half_d;
  logic        full_q, full_d;
  logic        accept;

  // Ready is forced low while reset is held, even before the reset edge lands.
  assign bus.sample_ready = reset_n & enable & (state_q != StWrite);
  assign accept           = bus.sample_valid & bus.sample_ready;

  // Next-state: packing, flush of a lone low half, and write completion.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    be_d     = be_q;
    wr_ptr_d = wr_ptr_q;
    wrap_d   = wrap_q;
    half_d   = 1'b0;
    full_d   = 1'b0;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          data_d[15:0] = bus.sample_data;
          state_d      = StHalf;
        end
      end
      StHalf: begin
        // A sample arriving with flush wins and completes the word.
        if (accept) begin
          data_d[31:16] = bus.sample_data;
          be_d          = 4'b1111;
          state_d       = StWrite;
        end else if (flush) begin
          data_d[31:16] = 16'h0000;
          be_d          = 4'b0011;
          state_d       = StWrite;
        end
      end
      StWrite: begin
        if (!bus.avm_waitrequest) begin
          half_d  = (wr_ptr_q == HalfOff);
          full_d  = (wr_ptr_q == LastOff);
          state_d = StEmpty;
          if (wr_ptr_q == LastOff) begin
            wr_ptr_d = '0;
            wrap_d   = wrap_q + 16'd1;
          end else begin
            wr_ptr_d = wr_ptr_q + 15'd1;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // State registers with synchronous active-low reset; a write in flight is dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StEmpty;
      data_q   <= '0;
      be_q     <= '0;
      wr_ptr_q <= '0;
      wrap_q   <= '0;
      half_q   <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      be_q     <= be_d;
      wr_ptr_q <= wr_ptr_d;
      wrap_q   <= wrap_d;
      half_q   <= half_d;
      full_q   <= full_d;
    end
  end

  // Outputs come straight from registers, so they hold steady across waitrequest.
  assign bus.avm_write      = (state_q == StWrite);
  assign bus.avm_address    = BaseAddr + wr_ptr_q;
  assign bus.avm_writedata  = data_q;
  assign bus.avm_byteenable = be_q;
  assign wr_ptr             = wr_ptr_q;
  assign wrap_count         = wrap_q;
  assign half_pulse         = half_q;
  assign full_pulse         = full_q;
  assign busy               = (state_q != StEmpty);

endmodule
